// File: rtl/instr_exec_reader.sv
`default_nettype none
// ============================================================================
// Module      : instr_exec_reader
// Description : Read-side engine for the instruction register. A start
//               command walks a range of locations (wrapping modulo DEPTH),
//               fetches each {opcode, op_a, op_b} word, executes it on a small
//               signed ALU and returns the result with its source address
//               over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
//
// instruction_word layout: {opc[3:0], op_a[31:0], op_b[31:0]}. The three
// fields need 4 + 32 + 32 = 68 bits, so the port width is derived from the
// operand width rather than fixed at a narrower value that could not hold
// two full 32-bit operands.

module instr_exec_reader #(
    parameter int DEPTH = 32,
    parameter int OPW   = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [$clog2(DEPTH)-1:0]      first_addr,
    input  logic [$clog2(DEPTH):0]        count,
    output logic [$clog2(DEPTH)-1:0]      read_pointer,
    input  logic [4+2*OPW-1:0]            instruction_word,
    output logic signed [2*OPW-1:0]       result,
    output logic [$clog2(DEPTH)-1:0]      result_addr,
    output logic                          result_err,
    output logic                          result_valid,
    input  logic                          result_ready,
    output logic                          busy,
    output logic                          done
);

    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int WORD_W = 4 + 2 * OPW;
    localparam int RW     = 2 * OPW;

    localparam logic [3:0] OPC_ZERO  = 4'd0;
    localparam logic [3:0] OPC_PASSA = 4'd1;
    localparam logic [3:0] OPC_PASSB = 4'd2;
    localparam logic [3:0] OPC_ADD   = 4'd3;
    localparam logic [3:0] OPC_SUB   = 4'd4;
    localparam logic [3:0] OPC_MULT  = 4'd5;
    localparam logic [3:0] OPC_DIV   = 4'd6;
    localparam logic [3:0] OPC_MOD   = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_OUT   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state_q,     state_d;
    logic [AW-1:0]         rp_q,        rp_d;
    logic [CW-1:0]         remaining_q, remaining_d;
    logic [WORD_W-1:0]     instr_q,     instr_d;
    logic [AW-1:0]         addr_q,      addr_d;
    logic signed [RW-1:0]  result_q,    result_d;
    logic                  err_q,       err_d;

    // ALU operands decoded from the captured instruction word
    logic [3:0]            alu_opc;
    logic signed [RW-1:0]  alu_a;
    logic signed [RW-1:0]  alu_b;
    logic signed [RW-1:0]  alu_divisor;
    logic signed [RW-1:0]  alu_quot;
    logic signed [RW-1:0]  alu_rem;
    logic                  alu_b_zero;
    logic signed [RW-1:0]  alu_res;
    logic                  alu_err;

    assign alu_opc = instr_q[WORD_W-1 -: 4];
    // Operands are widened to the result width first, so ADD/SUB/MULT/DIV
    // produce the exact mathematical value (no 32-bit wrap) and the
    // most-negative / -1 quotient is representable.
    assign alu_a   = {{OPW{instr_q[2*OPW-1]}}, instr_q[2*OPW-1:OPW]};
    assign alu_b   = {{OPW{instr_q[OPW-1]}},   instr_q[OPW-1:0]};

    assign alu_b_zero  = (instr_q[OPW-1:0] == '0);
    // A zero divisor is replaced by one so the divider never sees /0; the
    // result is then overridden to 0 with the error flag set.
    assign alu_divisor = alu_b_zero ? RW'(1) : alu_b;
    assign alu_quot    = alu_a / alu_divisor;
    assign alu_rem     = alu_a % alu_divisor;

    // Combinational ALU evaluated on the captured instruction word
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (alu_opc)
            OPC_ZERO:  alu_res = '0;
            OPC_PASSA: alu_res = alu_a;
            OPC_PASSB: alu_res = alu_b;
            OPC_ADD:   alu_res = alu_a + alu_b;
            OPC_SUB:   alu_res = alu_a - alu_b;
            OPC_MULT:  alu_res = alu_a * alu_b;
            OPC_DIV: begin
                if (alu_b_zero) begin
                    alu_err = 1'b1;
                end else begin
                    alu_res = alu_quot;
                end
            end
            OPC_MOD: begin
                if (alu_b_zero) begin
                    alu_err = 1'b1;
                end else begin
                    alu_res = alu_rem;
                end
            end
            default:   alu_err = 1'b1;
        endcase
    end

    // Next-state and datapath update for the walk sequencer
    always_comb begin
        state_d     = state_q;
        rp_d        = rp_q;
        remaining_d = remaining_q;
        instr_d     = instr_q;
        addr_d      = addr_q;
        result_d    = result_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (start && (count != '0)) begin
                    rp_d        = first_addr;
                    remaining_d = count;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                instr_d = instruction_word;
                addr_d  = rp_q;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                result_d = alu_res;
                err_d    = alu_err;
                state_d  = S_OUT;
            end
            S_OUT: begin
                if (result_ready) begin
                    if (remaining_q == CW'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        // Pointer wraps naturally at the address width
                        rp_d        = rp_q + AW'(1);
                        remaining_d = remaining_q - CW'(1);
                        state_d     = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any walk in progress
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            rp_q        <= '0;
            remaining_q <= '0;
            instr_q     <= '0;
            addr_q      <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rp_q        <= rp_d;
            remaining_q <= remaining_d;
            instr_q     <= instr_d;
            addr_q      <= addr_d;
            result_q    <= result_d;
            err_q       <= err_d;
        end
    end

    assign read_pointer = rp_q;
    assign result       = result_q;
    assign result_addr  = addr_q;
    assign result_err   = err_q;
    assign result_valid = (state_q == S_OUT);
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_instr_exec_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_exec_reader
// Description : Scoreboard bench for instr_exec_reader. Stimulus pushes the
//               hand-computed expected results; a monitor pops and compares
//               on every result handshake.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_instr_exec_reader;

    localparam int WORD_W = 68;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               start;
    logic [4:0]         first_addr;
    logic [5:0]         count;
    logic [4:0]         read_pointer;
    logic [WORD_W-1:0]  instruction_word;
    logic signed [63:0] result;
    logic [4:0]         result_addr;
    logic               result_err;
    logic               result_valid;
    logic               result_ready;
    logic               busy;
    logic               done;

    logic [WORD_W-1:0]  mem [32];

    typedef struct {
        logic [4:0]         addr;
        logic signed [63:0] res;
        logic               err;
    } exp_t;

    exp_t sbq[$];
    int   rise_q[$];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int hs_cnt = 0;
    int t0 = 0;

    always #5 clk = ~clk;

    assign instruction_word = mem[read_pointer];

    instr_exec_reader #(.DEPTH(32), .OPW(32)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .first_addr       (first_addr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .result           (result),
        .result_addr      (result_addr),
        .result_err       (result_err),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .busy             (busy),
        .done             (done)
    );

    function automatic logic [WORD_W-1:0] mk(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        return {o, a, b};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_push(input logic [4:0] ad, input logic signed [63:0] r, input logic er);
        exp_t e;
        e.addr = ad;
        e.res  = r;
        e.err  = er;
        sbq.push_back(e);
    endtask

    task automatic start_walk(input logic [4:0] fa, input logic [5:0] cnt);
        @(negedge clk);
        first_addr = fa;
        count      = cnt;
        start      = 1'b1;
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: done never pulsed (got 0 expected 1)", name);
        end
        // let the monitor observe this negedge before anyone reads its counters
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rp"},    64'(read_pointer), 64'd0);
        chk({tag, "_res"},   result,            64'd0);
        chk({tag, "_addr"},  64'(result_addr),  64'd0);
        chk({tag, "_err"},   64'(result_err),   64'd0);
        chk({tag, "_valid"}, 64'(result_valid), 64'd0);
        chk({tag, "_busy"},  64'(busy),         64'd0);
        chk({tag, "_done"},  64'(done),         64'd0);
    endtask

    // Cycle counter: number of rising edges seen
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: records valid rises, counts done pulses, scores handshakes
    initial begin
        bit   prev_valid = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (result_valid && !prev_valid) rise_q.push_back(cyc);
            prev_valid = result_valid;
            if (done) done_cnt++;
            if (result_valid && result_ready) begin
                hs_cnt++;
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_result: got addr %0d res %0d with no expected entry", result_addr, result);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_result", result,            e.res);
                    chk("sb_addr",   64'(result_addr),  64'(e.addr));
                    chk("sb_err",    64'(result_err),   64'(e.err));
                end
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_basic(input string tag);
        int d0;
        rise_q.delete();
        d0 = done_cnt;
        exp_push(5'd0, 12,  1'b0);
        exp_push(5'd1, -6,  1'b0);
        exp_push(5'd2, -24, 1'b0);
        start_walk(5'd0, 6'd3);
        wait_done(tag);
        chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, "_sb_empty"},    64'(sbq.size()),    64'd0);
        chk({tag, "_busy_low"},    64'(busy),          64'd0);
        chk({tag, "_valid_rises"}, 64'(rise_q.size()), 64'd3);
        if (rise_q.size() >= 3) begin
            // start sampled at E0; first result valid from E2, last from E8
            chk({tag, "_lat_first"}, 64'(rise_q[0] - t0), 64'd2);
            chk({tag, "_lat_last"},  64'(rise_q[2] - t0), 64'd8);
        end
    endtask

    initial begin
        int d0;
        int h;
        bit hit;
        reset_n      = 1'b0;
        start        = 1'b0;
        first_addr   = '0;
        count        = '0;
        result_ready = 1'b1;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[0]  = mk(4'd3, 32'sd5, 32'sd7);
        mem[1]  = mk(4'd4, 32'sd3, 32'sd9);
        mem[2]  = mk(4'd5, -32'sd4, 32'sd6);
        mem[5]  = mk(4'd6, 32'sd7, 32'sd0);
        mem[6]  = mk(4'd7, -32'sd7, 32'sd2);
        mem[7]  = mk(4'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        mem[8]  = mk(4'd9, 32'sd1, 32'sd1);
        mem[9]  = mk(4'd3, 32'h7FFF_FFFF, 32'sd1);
        mem[10] = mk(4'd2, 32'sd0, -32'sd55);
        mem[31] = mk(4'd1, 32'sd100, 32'sd0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Basic three-entry walk with latency and done checks
        run_basic("basic");

        // Division / modulo corners, illegal opcode, wide add
        exp_push(5'd5, 0,                 1'b1);
        exp_push(5'd6, -1,                1'b0);
        exp_push(5'd7, 64'sd2147483648,   1'b0);
        exp_push(5'd8, 0,                 1'b1);
        exp_push(5'd9, 64'sd2147483648,   1'b0);
        start_walk(5'd5, 6'd5);
        wait_done("alu");
        chk("alu_sb_empty", 64'(sbq.size()), 64'd0);

        // Address wrap-around 31 -> 0
        exp_push(5'd31, 100, 1'b0);
        exp_push(5'd0,  12,  1'b0);
        start_walk(5'd31, 6'd2);
        wait_done("wrap");
        chk("wrap_sb_empty", 64'(sbq.size()), 64'd0);

        // Output stall with start pulses while busy
        result_ready = 1'b0;
        exp_push(5'd10, -55, 1'b0);
        start_walk(5'd10, 6'd1);
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (result_valid) hit = 1;
        end
        chk("stall_valid_seen", 64'(hit), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(result_valid), 64'd1);
            chk("stall_res",   result,            -64'sd55);
            chk("stall_addr",  64'(result_addr),  64'd10);
            chk("stall_rp",    64'(read_pointer), 64'd10);
            if (i == 1) begin
                first_addr = 5'd3;
                count      = 6'd5;
                start      = 1'b1;
            end
            if (i == 3) start = 1'b0;
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        result_ready = 1'b1;
        wait_done("stall");
        repeat (4) @(negedge clk);
        chk("stall_busy_after", 64'(busy),       64'd0);
        chk("stall_sb_empty",   64'(sbq.size()), 64'd0);

        // count = 0 is ignored
        start_walk(5'd4, 6'd0);
        @(negedge clk);
        chk("cnt0_busy_a", 64'(busy), 64'd0);
        @(negedge clk);
        chk("cnt0_busy_b", 64'(busy), 64'd0);

        // Reset during EXEC of the second entry
        exp_push(5'd0, 12, 1'b0);
        h = hs_cnt;
        start_walk(5'd0, 6'd3);
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(posedge clk);
            if (hs_cnt == h + 1) hit = 1;
        end
        chk("rst_first_hs", 64'(hit), 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk("rst_pre_busy",  64'(busy),         64'd1);
        chk("rst_pre_valid", 64'(result_valid), 64'd0);
        d0 = done_cnt;
        reset_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        chk("midrst_busy",    64'(busy),          64'd0);
        chk("midrst_sb",      64'(sbq.size()),    64'd0);

        // Normal operation after reset
        run_basic("post_rst");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
